data_mem_ctrl: RTL



---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_array.sv | 56 +++++
 rtl/data_mem_ctrl.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/dmem_pkg.sv
// Shared types and sizing helpers for the data-memory controller.
package dmem_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } dmem_state_e;

   // Byte lanes per 32-bit word.
   localparam int unsigned LANES = 4;

   // Default sizing; instances with other parameters derive widths via the helpers.
   localparam int unsigned DEF_DEPTH   = 1024;
   localparam int unsigned DEF_LATENCY = 2;
   localparam int unsigned IDX_W       = $clog2(DEF_DEPTH);
   localparam int unsigned CNT_W       = $clog2(DEF_LATENCY + 1);

   function automatic int unsigned idx_width(input int unsigned depth);
      return $clog2(depth);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned latency);
      return $clog2(latency + 1);
   endfunction

endpackage

// File: rtl/dmem_array.sv
// Single-port byte-enabled word array. The read register only updates on a
// load access, so it holds the last loaded word between loads.
module dmem_array
   import dmem_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Depth     = 1024,
   parameter int unsigned IdxW      = 10
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 en,
   input  logic                 we,
   input  logic [LANES-1:0]     be,
   input  logic [IdxW-1:0]      idx,
   input  logic [DataWidth-1:0] wdata,
   output logic [DataWidth-1:0] rdata
);

   localparam int unsigned LaneW = DataWidth / LANES;

   logic [DataWidth-1:0] mem_q [Depth];
   logic [DataWidth-1:0] rdata_q;
   logic [DataWidth-1:0] rdata_d;

   // Next read value: refresh only on an enabled load.
   always_comb begin
      rdata_d = rdata_q;
      if (en && !we) begin
         rdata_d = mem_q[idx];
      end
   end

   // Read register; cleared by reset, unlike the array contents.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdata_q <= '0;
      end else begin
         rdata_q <= rdata_d;
      end
   end

   // Byte-lane writes; an all-zero enable writes nothing.
   always_ff @(posedge clk) begin
      if (en && we) begin
         for (int i = 0; i < int'(LANES); i++) begin
            if (be[i]) begin
               mem_q[idx][i*LaneW +: LaneW] <= wdata[i*LaneW +: LaneW];
            end
         end
      end
   end

   assign rdata = rdata_q;

endmodule

// File: rtl/data_mem_ctrl.sv
// Data-memory controller: accepts one load/store from the memory stage,
// holds the core for the wait-state latency, then pulses data_valid.
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned Depth     = 1024,
   parameter int unsigned Latency   = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 request,
   input  logic                 we_re,
   input  logic [LANES-1:0]     mask,
   input  logic [DataWidth-1:0] address,
   input  logic [DataWidth-1:0] store_data,
   output logic [DataWidth-1:0] load_data,
   output logic                 data_valid,
   output logic                 stall
);

   localparam int unsigned IdxW = idx_width(Depth);
   localparam int unsigned CntW = cnt_width(Latency);

   dmem_state_e          state_q, state_d;
   logic [CntW-1:0]      cnt_q, cnt_d;
   logic                 we_q, we_d;
   logic [LANES-1:0]     mask_q, mask_d;
   logic [IdxW-1:0]      idx_q, idx_d;
   logic [DataWidth-1:0] wdata_q, wdata_d;
   logic                 dv_q, dv_d;
   logic                 stall_c;

   logic [IdxW-1:0]      in_idx;
   logic                 arr_en;
   logic                 arr_we;
   logic [LANES-1:0]     arr_be;
   logic [IdxW-1:0]      arr_idx;
   logic [DataWidth-1:0] arr_wdata;
   logic                 unused_addr_bits;

   // Out-of-range addresses wrap: only the word-index bits are decoded.
   assign in_idx           = address[IdxW+1:2];
   assign unused_addr_bits = ^{address[DataWidth-1:IdxW+2], address[1:0]};

   // Next-state, capture and counter logic.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      we_d    = we_q;
      mask_d  = mask_q;
      idx_d   = idx_q;
      wdata_d = wdata_q;
      stall_c = 1'b0;
      case (state_q)
         IDLE: begin
            stall_c = request;
            if (request) begin
               we_d    = we_re;
               mask_d  = mask;
               idx_d   = in_idx;
               wdata_d = store_data;
               cnt_d   = CntW'(Latency - 1);
               state_d = (Latency == 1) ? RESP : BUSY;
            end
         end
         BUSY: begin
            stall_c = 1'b1;
            cnt_d   = cnt_q - 1'b1;
            if (cnt_q == CntW'(1)) begin
               state_d = RESP;
            end
         end
         RESP: begin
            cnt_d   = '0;
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
      dv_d = (state_d == RESP);
   end

   // The array access happens on the edge that enters RESP. With a one-cycle
   // latency that edge is also the capture edge, so the live inputs are used.
   always_comb begin
      arr_en = rst_n && (state_d == RESP);
      if (state_q == IDLE) begin
         arr_we    = we_re;
         arr_be    = mask;
         arr_idx   = in_idx;
         arr_wdata = store_data;
      end else begin
         arr_we    = we_q;
         arr_be    = mask_q;
         arr_idx   = idx_q;
         arr_wdata = wdata_q;
      end
   end

   // State, counter, captured request and completion pulse registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         we_q    <= 1'b0;
         mask_q  <= '0;
         idx_q   <= '0;
         wdata_q <= '0;
         dv_q    <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         we_q    <= we_d;
         mask_q  <= mask_d;
         idx_q   <= idx_d;
         wdata_q <= wdata_d;
         dv_q    <= dv_d;
      end
   end

   dmem_array #(
      .DataWidth (DataWidth),
      .Depth     (Depth),
      .IdxW      (IdxW)
   ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (arr_en),
      .we    (arr_we),
      .be    (arr_be),
      .idx   (arr_idx),
      .wdata (arr_wdata),
      .rdata (load_data)
   );

   // Stall is combinational on the accept cycle; reset forces it low at once.
   assign stall      = rst_n & stall_c;
   assign data_valid = dv_q;

endmodule
